// File: rtl/step_counter.sv
// Up/down step counter running counted bursts of single steps through IncDec under a start/done handshake.
// Optional saturation at the boundaries when STEPCNT_SAT_EN is defined; otherwise the value wraps modulo 2^width.

module IncDec #(
   parameter int width = 4
) (
   input  logic [width-1:0] A,
   input  logic             DecEn,
   output logic [width-1:0] S,
   output logic             Boundary
);

   localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

   always_comb begin
      S        = A + one;
      Boundary = (A == {width{1'b1}});
      if (DecEn) begin
         S        = A - one;
         Boundary = (A == {width{1'b0}});
      end
   end

endmodule

module step_counter #(
   parameter int width = 4
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             Load,
   input  logic [width-1:0] LoadVal,
   input  logic             Start,
   input  logic             Dir,
   input  logic [width-1:0] Steps,
   input  logic             Hold,
   output logic [width-1:0] Q,
   output logic             Busy,
   output logic             Done,
   output logic             Carry
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};

   state_t           state;
   logic [width-1:0] q;
   logic [width-1:0] rem;
   logic             dirR;
   logic             busyR;
   logic             doneR;
   logic             carryR;

   logic [width-1:0] stepVal;
   logic             crossing;
   logic [width-1:0] nextQ;

   IncDec #(.width(width)) uIncDec (
      .A        (q),
      .DecEn    (dirR),
      .S        (stepVal),
      .Boundary (crossing)
   );

`ifdef STEPCNT_SAT_EN
   // A boundary step pins the value at all-ones (up) or zero (down) instead of wrapping.
   assign nextQ = crossing ? q : stepVal;
`else
   assign nextQ = stepVal;
`endif

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state  <= IDLE;
         q      <= '0;
         rem    <= '0;
         dirR   <= 1'b0;
         busyR  <= 1'b0;
         doneR  <= 1'b0;
         carryR <= 1'b0;
      end else begin
         carryR <= 1'b0;
         case (state)
            IDLE: begin
               if (Load) begin
                  q <= LoadVal;
               end else if (Start) begin
                  if (Steps != '0) begin
                     rem   <= Steps;
                     dirR  <= Dir;
                     busyR <= 1'b1;
                     state <= RUN;
                  end else begin
                     doneR <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            RUN: begin
               if (!Hold) begin
                  q      <= nextQ;
                  carryR <= crossing;
                  rem    <= rem - one;
                  if (rem == one) begin
                     busyR <= 1'b0;
                     doneR <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               doneR <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busyR <= 1'b0;
               doneR <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign Q     = q;
   assign Busy  = busyR;
   assign Done  = doneR;
   assign Carry = carryR;

endmodule

// File: tb/tb_step_counter.sv
// Directed bench for step_counter: per-cycle expected outputs are queued by the stimulus and checked by a monitor.

module tb_step_counter;

   localparam int width = 4;

   logic             CLK;
   logic             nRST;
   logic             Load;
   logic [width-1:0] LoadVal;
   logic             Start;
   logic             Dir;
   logic [width-1:0] Steps;
   logic             Hold;
   logic [width-1:0] Q;
   logic             Busy;
   logic             Done;
   logic             Carry;

   typedef struct {
      string            name;
      logic [width-1:0] q;
      logic             busy;
      logic             done;
      logic             carry;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   step_counter #(.width(width)) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .Load    (Load),
      .LoadVal (LoadVal),
      .Start   (Start),
      .Dir     (Dir),
      .Steps   (Steps),
      .Hold    (Hold),
      .Q       (Q),
      .Busy    (Busy),
      .Done    (Done),
      .Carry   (Carry)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkNow(input string name, input logic [width-1:0] eq, input logic eb,
                           input logic ed, input logic ec);
      checks++;
      if (Q !== eq || Busy !== eb || Done !== ed || Carry !== ec) begin
         failures++;
         $display("FAIL %s: got Q=%0d Busy=%b Done=%b Carry=%b, expected Q=%0d Busy=%b Done=%b Carry=%b",
                  name, Q, Busy, Done, Carry, eq, eb, ed, ec);
      end
   endtask

   // Monitor: each expectation applies to the outputs after the edge that preceded its push.
   always @(negedge CLK) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         checkNow(e.name, e.q, e.busy, e.done, e.carry);
      end
   end

   // Drive inputs for one edge, then queue the outputs expected after that edge.
   task automatic cyc(input string name, input logic ld, input logic [width-1:0] lv,
                      input logic st, input logic dr, input logic [width-1:0] sp, input logic hd,
                      input logic [width-1:0] eq, input logic eb, input logic ed, input logic ec);
      exp_t e;
      Load = ld; LoadVal = lv; Start = st; Dir = dr; Steps = sp; Hold = hd;
      @(posedge CLK);
      #2;
      e.name = name; e.q = eq; e.busy = eb; e.done = ed; e.carry = ec;
      expQ.push_back(e);
   endtask

   task automatic idle(input string name, input logic hd, input logic [width-1:0] eq,
                       input logic eb, input logic ed, input logic ec);
      cyc(name, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, hd, eq, eb, ed, ec);
   endtask

   initial begin
      nRST = 1'b0; Load = 1'b0; LoadVal = '0; Start = 1'b0; Dir = 1'b0; Steps = '0; Hold = 1'b0;
      #3;
      checkNow("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
      #9 nRST = 1'b1;
      @(posedge CLK);
      #2;

      // Increment burst of 4 from 3, with Load/Start poked during RUN and DONE.
      cyc ("inc_load",     1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc ("inc_start",    1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      idle("inc_s1",       1'b0,                               4'd4, 1'b1, 1'b0, 1'b0);
      cyc ("inc_s2_poke",  1'b1, 4'd9, 1'b1, 1'b1, 4'd2, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0);
      idle("inc_s3",       1'b0,                               4'd6, 1'b1, 1'b0, 1'b0);
      idle("inc_s4_done",  1'b0,                               4'd7, 1'b0, 1'b1, 1'b0);
      cyc ("inc_done_poke",1'b1, 4'd9, 1'b1, 1'b0, 4'd2, 1'b0, 4'd7, 1'b0, 1'b0, 1'b0);
      idle("inc_idle",     1'b0,                               4'd7, 1'b0, 1'b0, 1'b0);

      // Upward boundary from 14 in 3 steps.
      cyc ("wrap_load",    1'b1, 4'd14, 1'b0, 1'b0, 4'd0, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0);
      cyc ("wrap_start",   1'b0, 4'd0,  1'b1, 1'b0, 4'd3, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0);
      idle("wrap_s1",      1'b0,                                4'd15, 1'b1, 1'b0, 1'b0);
`ifdef STEPCNT_SAT_EN
      idle("sat_s2",       1'b0,                                4'd15, 1'b1, 1'b0, 1'b1);
      idle("sat_s3_done",  1'b0,                                4'd15, 1'b0, 1'b1, 1'b1);
      idle("sat_idle",     1'b0,                                4'd15, 1'b0, 1'b0, 1'b0);
`else
      idle("wrap_s2",      1'b0,                                4'd0,  1'b1, 1'b0, 1'b1);
      idle("wrap_s3_done", 1'b0,                                4'd1,  1'b0, 1'b1, 1'b0);
      idle("wrap_idle",    1'b0,                                4'd1,  1'b0, 1'b0, 1'b0);
`endif

      // Downward burst of 2 from 1 with two Hold cycles after the first step.
      cyc ("dec_load",     1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0);
      cyc ("dec_start",    1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0);
      idle("dec_s1",       1'b0,                               4'd0, 1'b1, 1'b0, 1'b0);
      idle("dec_hold1",    1'b1,                               4'd0, 1'b1, 1'b0, 1'b0);
      idle("dec_hold2",    1'b1,                               4'd0, 1'b1, 1'b0, 1'b0);
`ifdef STEPCNT_SAT_EN
      idle("dec_s2_done",  1'b0,                               4'd0, 1'b0, 1'b1, 1'b1);
`else
      idle("dec_s2_done",  1'b0,                               4'd15, 1'b0, 1'b1, 1'b1);
`endif
      cyc ("dec_idle",     1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, Q, 1'b0, 1'b0, 1'b0);

      // Load wins over Start; zero-step Start pulses Done only.
      cyc ("prio_load",    1'b1, 4'd9, 1'b1, 1'b0, 4'd3, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0);
      idle("prio_noburst", 1'b0,                               4'd9, 1'b0, 1'b0, 1'b0);
      cyc ("zero_start",   1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1, 1'b0);
      idle("zero_done_low",1'b0,                               4'd9, 1'b0, 1'b0, 1'b0);

      // Reset mid-burst with Q=5, two steps remaining.
      cyc ("rst_load",     1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b0, 1'b0, 1'b0);
      cyc ("rst_start",    1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0);
      idle("rst_s1",       1'b0,                               4'd4, 1'b1, 1'b0, 1'b0);
      idle("rst_s2",       1'b0,                               4'd5, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      #1 nRST = 1'b0;
      #1 checkNow("rst_async", 4'd0, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      #2 nRST = 1'b1;
      idle("rst_after1",   1'b0,                               4'd0, 1'b0, 1'b0, 1'b0);
      idle("rst_after2",   1'b0,                               4'd0, 1'b0, 1'b0, 1'b0);
      idle("rst_after3",   1'b0,                               4'd0, 1'b0, 1'b0, 1'b0);

      // Single decrement step from 0 after reset.
      cyc ("one_start",    1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
`ifdef STEPCNT_SAT_EN
      idle("one_done",     1'b0,                               4'd0, 1'b0, 1'b1, 1'b1);
`else
      idle("one_done",     1'b0,                               4'd15, 1'b0, 1'b1, 1'b1);
`endif

      repeat (3) @(posedge CLK);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("FAIL queue_drain: %0d expectations left, expected 0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
